// File: rtl/panel_lamps_pkg.sv
// Shared timing defaults, frame geometry and state encodings for the front-panel lamp driver.
package panel_lamps_pkg;

`ifdef SIM
  localparam int DEF_SHIFT_DIV  = 1;
  localparam int DEF_DWELL_BITS = 3;
`else
  localparam int CLK_FREQ_HZ    = 50_000_000;
  localparam int DEF_SHIFT_DIV  = 4;
  localparam int DEF_DWELL_BITS = $clog2(CLK_FREQ_HZ) - 10;
`endif

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_LO,
    SH_HI,
    SH_LATCH
  } shift_state_e;

  typedef enum logic [1:0] {
    SC_LOAD,
    SC_SHIFT,
    SC_DWELL
  } scan_state_e;

  function automatic logic [3:0] rowOneHot(input logic [1:0] row);
    return 4'b0001 << row;
  endfunction

endpackage

// File: rtl/panel_shift_out.sv
// 16-bit MSB-first serializer for 74HC595-style chains: sclk/sdata phases,
// then an rclk latch pulse, with a start/done handshake to the scanner.
module panel_shift_out
  import panel_lamps_pkg::*;
#(
  parameter int SHIFT_DIV = DEF_SHIFT_DIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               sclk_o,
  output logic               sdata_o,
  output logic               rclk_o,
  output logic               done_o
);

  localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);

  shift_state_e       state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [3:0]         bitCnt_q, bitCnt_d;
  logic [DIV_W-1:0]   divCnt_q, divCnt_d;
  logic               sclk_q, sclk_d;
  logic               rclk_q, rclk_d;
  logic               phaseEnd;

  assign phaseEnd = (divCnt_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SH_IDLE;
      shreg_q  <= '0;
      bitCnt_q <= '0;
      divCnt_q <= '0;
      sclk_q   <= 1'b0;
      rclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitCnt_q <= bitCnt_d;
      divCnt_q <= divCnt_d;
      sclk_q   <= sclk_d;
      rclk_q   <= rclk_d;
    end
  end

  // sclk and sdata only move together on the falling step of sclk, so data has
  // a full low phase of setup before the next rising edge.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitCnt_d = bitCnt_q;
    divCnt_d = divCnt_q + 1'b1;
    sclk_d   = sclk_q;
    rclk_d   = rclk_q;
    done_o   = 1'b0;

    case (state_q)
      SH_IDLE: begin
        divCnt_d = '0;
        if (start_i) begin
          shreg_d  = frame_i;
          bitCnt_d = 4'd15;
          sclk_d   = 1'b0;
          state_d  = SH_LO;
        end
      end
      SH_LO: begin
        if (phaseEnd) begin
          divCnt_d = '0;
          sclk_d   = 1'b1;
          state_d  = SH_HI;
        end
      end
      SH_HI: begin
        if (phaseEnd) begin
          divCnt_d = '0;
          sclk_d   = 1'b0;
          if (bitCnt_q == 4'd0) begin
            rclk_d  = 1'b1;
            state_d = SH_LATCH;
          end else begin
            bitCnt_d = bitCnt_q - 4'd1;
            shreg_d  = {shreg_q[FRAME_W-2:0], 1'b0};
            state_d  = SH_LO;
          end
        end
      end
      SH_LATCH: begin
        if (phaseEnd) begin
          divCnt_d = '0;
          rclk_d   = 1'b0;
          done_o   = 1'b1;
          state_d  = SH_IDLE;
        end
      end
      default: begin
        state_d = SH_IDLE;
      end
    endcase
  end

  assign sclk_o  = sclk_q;
  assign rclk_o  = rclk_q;
  assign sdata_o = shreg_q[FRAME_W-1];

endmodule

// File: rtl/panel_lamps.sv
// Front-panel lamp scanner: walks four rows, snapshots each row's data into
// a frame for the serializer, then dwells so the latched row stays lit.
module panel_lamps
  import panel_lamps_pkg::*;
#(
  parameter int SHIFT_DIV  = DEF_SHIFT_DIV,
  parameter int DWELL_BITS = DEF_DWELL_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ma,
  input  logic [DATA_W-1:0] mb,
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] mq,
  input  logic              reg_sel,
  input  logic [2:0]        ea,
  input  logic [4:0]        state,
  input  logic              link,
  input  logic              run,
  input  logic              sw_active,
  output logic              lamp_sclk,
  output logic              lamp_sdata,
  output logic              lamp_rclk,
  output logic              lamp_oe_n,
  output logic              frame_done
);

  scan_state_e         scan_q, scan_d;
  logic [1:0]          row_q, row_d;
  logic [DWELL_BITS:0] dwellCnt_q, dwellCnt_d;
  logic [DWELL_BITS:0] dwellNext;
  logic                oeN_q, oeN_d;
  logic                frameDone_q, frameDone_d;

  logic                shiftStart;
  logic                shiftDone;
  logic [DATA_W-1:0]   rowData;
  logic [FRAME_W-1:0]  frame;

  // Row data is only sampled by the serializer during LOAD, which is what
  // keeps a row from ever showing a half-updated register.
  always_comb begin
    rowData = ma;
    case (row_q)
      2'd0: rowData = ma;
      2'd1: rowData = mb;
      2'd2: rowData = reg_sel ? mq : ac;
      2'd3: rowData = {link, run, sw_active, ea, state, 1'b0};
      default: rowData = ma;
    endcase
  end

  assign frame     = {rowOneHot(row_q), rowData};
  assign dwellNext = dwellCnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q      <= SC_LOAD;
      row_q       <= 2'd0;
      dwellCnt_q  <= '0;
      oeN_q       <= 1'b1;
      frameDone_q <= 1'b0;
    end else begin
      scan_q      <= scan_d;
      row_q       <= row_d;
      dwellCnt_q  <= dwellCnt_d;
      oeN_q       <= oeN_d;
      frameDone_q <= frameDone_d;
    end
  end

  always_comb begin
    scan_d      = scan_q;
    row_d       = row_q;
    dwellCnt_d  = dwellCnt_q;
    oeN_d       = oeN_q;
    frameDone_d = 1'b0;
    shiftStart  = 1'b0;

    case (scan_q)
      SC_LOAD: begin
        shiftStart = 1'b1;
        scan_d     = SC_SHIFT;
      end
      SC_SHIFT: begin
        if (shiftDone) begin
          dwellCnt_d  = '0;
          oeN_d       = 1'b0;
          frameDone_d = (row_q == 2'd3);
          scan_d      = SC_DWELL;
        end
      end
      SC_DWELL: begin
        dwellCnt_d = dwellNext;
        if (dwellNext[DWELL_BITS]) begin
          row_d  = row_q + 2'd1;
          scan_d = SC_LOAD;
        end
      end
      default: begin
        scan_d = SC_LOAD;
      end
    endcase
  end

  panel_shift_out #(
    .SHIFT_DIV(SHIFT_DIV)
  ) u_shift_out (
    .clk    (clk),
    .reset  (reset),
    .start_i(shiftStart),
    .frame_i(frame),
    .sclk_o (lamp_sclk),
    .sdata_o(lamp_sdata),
    .rclk_o (lamp_rclk),
    .done_o (shiftDone)
  );

  assign lamp_oe_n  = oeN_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_panel_lamps.sv
// Directed bench for panel_lamps with short scan timing (SHIFT_DIV=1, DWELL_BITS=3, 42-clock rows).
// Edge n is the n-th rising clock edge after reset is released; outputs are sampled 1ns after it.
module tb_panel_lamps;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] ma = '0, mb = '0, ac = '0, mq = '0;
  logic        reg_sel = 1'b0;
  logic [2:0]  ea = '0;
  logic [4:0]  cpuState = '0;
  logic        link = 1'b0, run = 1'b0, sw_active = 1'b0;
  logic        lamp_sclk, lamp_sdata, lamp_rclk, lamp_oe_n, frame_done;

  int assertCount = 0;
  int failCount   = 0;

  int          edgeNum;
  logic        prevSclk, prevRclk, prevSdata;
  logic [15:0] shiftAcc;
  int          riseCount, firstRise, riseAtLatch0, oeFirst, oeRelapse;
  int          rclkHighCycles, setupViol;
  logic [15:0] frameQ[$];
  int          rclkEdgeQ[$];
  int          doneEdgeQ[$];

  panel_lamps #(
    .SHIFT_DIV (1),
    .DWELL_BITS(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ma        (ma),
    .mb        (mb),
    .ac        (ac),
    .mq        (mq),
    .reg_sel   (reg_sel),
    .ea        (ea),
    .state     (cpuState),
    .link      (link),
    .run       (run),
    .sw_active (sw_active),
    .lamp_sclk (lamp_sclk),
    .lamp_sdata(lamp_sdata),
    .lamp_rclk (lamp_rclk),
    .lamp_oe_n (lamp_oe_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearMonitor();
    edgeNum        = 0;
    prevSclk       = 1'b0;
    prevRclk       = 1'b0;
    prevSdata      = 1'b0;
    shiftAcc       = '0;
    riseCount      = 0;
    firstRise      = -1;
    riseAtLatch0   = -1;
    oeFirst        = -1;
    oeRelapse      = 0;
    rclkHighCycles = 0;
    setupViol      = 0;
    frameQ.delete();
    rclkEdgeQ.delete();
    doneEdgeQ.delete();
  endtask

  // Advance one clock and reconstruct what an external 595 chain would see.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    edgeNum++;
    if (lamp_sclk && !prevSclk) begin
      shiftAcc = {shiftAcc[14:0], lamp_sdata};
      riseCount++;
      if (firstRise < 0) firstRise = edgeNum;
    end
    if (lamp_sdata !== prevSdata && lamp_sclk) setupViol++;
    if (lamp_rclk && !prevRclk) begin
      frameQ.push_back(shiftAcc);
      rclkEdgeQ.push_back(edgeNum);
      if (riseAtLatch0 < 0) riseAtLatch0 = riseCount;
    end
    if (lamp_rclk) rclkHighCycles++;
    if (!lamp_oe_n && oeFirst < 0) oeFirst = edgeNum;
    if (lamp_oe_n && oeFirst >= 0) oeRelapse++;
    if (frame_done) doneEdgeQ.push_back(edgeNum);
    prevSclk  = lamp_sclk;
    prevRclk  = lamp_rclk;
    prevSdata = lamp_sdata;
  endtask

  task automatic applyStimulus(input logic [11:0] maV, input logic [11:0] mbV, input logic [11:0] acV,
                               input logic [11:0] mqV, input logic selV);
    ma      = maV;
    mb      = mbV;
    ac      = acV;
    mq      = mqV;
    reg_sel = selV;
  endtask

  function automatic logic [31:0] frameAt(input int idx);
    return (frameQ.size() > idx) ? {16'h0, frameQ[idx]} : 32'hDEAD_BEEF;
  endfunction

  function automatic int intAt(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  initial begin
    int rclkBefore;

    clearMonitor();
    applyStimulus(12'o7070, 12'o0017, 12'o4321, 12'o1234, 1'b1);
    link      = 1'b1;
    run       = 1'b1;
    sw_active = 1'b0;
    ea        = 3'b101;
    cpuState  = 5'b00011;
    reset     = 1'b1;
    repeat (3) stepCycle();

    checkOutput("reset sdata", lamp_sdata, 0);
    checkOutput("reset sclk", lamp_sclk, 0);
    checkOutput("reset rclk", lamp_rclk, 0);
    checkOutput("reset frame_done", frame_done, 0);
    checkOutput("reset oe_n", lamp_oe_n, 1);

    reset = 1'b0;
    clearMonitor();
    for (int n = 1; n <= 340; n++) begin
      stepCycle();
      if (n == 10) ma = 12'o0707;
      if (n == 130) reg_sel = 1'b0;
    end

    checkOutput("first sclk rise edge", firstRise, 2);
    checkOutput("sclk rises per frame", riseAtLatch0, 16);
    checkOutput("row0 rclk edge", intAt(rclkEdgeQ, 0), 33);
    checkOutput("oe_n low edge", oeFirst, 34);
    checkOutput("oe_n stays low", oeRelapse, 0);
    checkOutput("latch count", rclkEdgeQ.size(), 8);
    checkOutput("rclk width total", rclkHighCycles, 8);
    checkOutput("row0 frame", frameAt(0), {16'h0, 4'b0001, 12'o7070});
    checkOutput("row1 frame", frameAt(1), {16'h0, 4'b0010, 12'o0017});
    checkOutput("row2 frame mq", frameAt(2), {16'h0, 4'b0100, 12'o1234});
    checkOutput("row3 frame", frameAt(3), {16'h0, 4'b1000, 12'b1_1_0_101_00011_0});
    checkOutput("row0 rescan new ma", frameAt(4), {16'h0, 4'b0001, 12'o0707});
    checkOutput("row1 rescan", frameAt(5), {16'h0, 4'b0010, 12'o0017});
    checkOutput("row2 frame ac", frameAt(6), {16'h0, 4'b0100, 12'o4321});
    checkOutput("row3 rescan", frameAt(7), {16'h0, 4'b1000, 12'b1_1_0_101_00011_0});
    checkOutput("row1 rclk edge", intAt(rclkEdgeQ, 1), 75);
    checkOutput("frame_done count", doneEdgeQ.size(), 2);
    checkOutput("frame_done first edge", intAt(doneEdgeQ, 0), 160);
    checkOutput("frame_done second edge", intAt(doneEdgeQ, 1), 328);
    checkOutput("sdata moved while sclk high", setupViol, 0);

    reset = 1'b1;
    repeat (3) stepCycle();
    reset = 1'b0;
    clearMonitor();
    repeat (50) stepCycle();
    checkOutput("row1 in shift_hi", lamp_sclk, 1);
    checkOutput("latches before abort", rclkEdgeQ.size(), 1);
    rclkBefore = rclkHighCycles;

    reset = 1'b1;
    stepCycle();
    checkOutput("abort sdata", lamp_sdata, 0);
    checkOutput("abort sclk", lamp_sclk, 0);
    checkOutput("abort rclk", lamp_rclk, 0);
    checkOutput("abort frame_done", frame_done, 0);
    checkOutput("abort oe_n", lamp_oe_n, 1);
    repeat (2) stepCycle();
    checkOutput("no rclk for aborted row", rclkHighCycles, rclkBefore);

    reset = 1'b0;
    clearMonitor();
    repeat (40) stepCycle();
    checkOutput("restart sclk rise edge", firstRise, 2);
    checkOutput("restart rclk edge", intAt(rclkEdgeQ, 0), 33);
    checkOutput("restart row0 frame", frameAt(0), {16'h0, 4'b0001, 12'o0707});

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
